// File: rtl/mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Byte-wide RAM/IO port owner; arbitrates fetch vs load/store and
//            serialises each access into little-endian byte transfers.
// Revision : 1.0  initial release
// ============================================================================
module mem_ctrl #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = 'h30000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clr_in,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              IF_MC_ask,
    input  logic [ADDR_W-1:0] IF_MC_Addr,
    output logic              MC_IF_ok,
    output logic              MC_IF_arrive,
    output logic [31:0]       MC_IF_Inst,
    input  logic              LS_MC_ask,
    input  logic              LS_MC_wr,
    input  logic [ADDR_W-1:0] LS_MC_Addr,
    input  logic [1:0]        LS_MC_len,
    input  logic [31:0]       LS_MC_data,
    output logic              MC_LS_ok,
    output logic              MC_LS_arrive,
    output logic [31:0]       MC_LS_data
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_READ  = 2'd1,
        LS_READ  = 2'd2,
        LS_WRITE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic              last_ls_q, last_ls_d;
    logic [7:0]        dout_q, dout_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic              if_ok_q, if_ok_d, if_arr_q, if_arr_d;
    logic              ls_ok_q, ls_ok_d, ls_arr_q, ls_arr_d;
    logic [31:0]       inst_q, inst_d, ls_data_q, ls_data_d;

    logic              io_hit, ls_req, grant_ls, grant_if;
    logic [2:0]        ls_len, cnt_inc;
    logic [1:0]        rd_idx;

    // A blocked IO store simply does not count as a request this cycle
    assign io_hit   = (LS_MC_Addr - IO_BASE) < ADDR_W'(8);
    assign ls_req   = LS_MC_ask && !(LS_MC_wr && io_hit && io_buffer_full);
    assign grant_ls = ls_req && !(IF_MC_ask && last_ls_q);
    assign grant_if = IF_MC_ask && !grant_ls;
    assign ls_len   = (LS_MC_len == 2'd0) ? 3'd1 : (LS_MC_len == 2'd1) ? 3'd2 : 3'd4;
    assign cnt_inc  = cnt_q + 3'd1;
    assign rd_idx   = cnt_q[1:0] - 2'd1;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        wdata_d   = wdata_q;
        rbuf_d    = rbuf_q;
        last_ls_d = last_ls_q;
        dout_d    = dout_q;
        addr_d    = addr_q;
        wr_d      = 1'b0;
        if_ok_d   = 1'b0;
        if_arr_d  = 1'b0;
        ls_ok_d   = 1'b0;
        ls_arr_d  = 1'b0;
        inst_d    = inst_q;
        ls_data_d = ls_data_q;

        case (state_q)
            IDLE: begin
                if (!clr_in && grant_ls) begin
                    state_d   = LS_MC_wr ? LS_WRITE : LS_READ;
                    base_d    = LS_MC_Addr;
                    addr_d    = LS_MC_Addr;
                    len_d     = ls_len;
                    wdata_d   = LS_MC_data;
                    cnt_d     = 3'd0;
                    rbuf_d    = 32'd0;
                    ls_ok_d   = 1'b1;
                    last_ls_d = 1'b1;
                    wr_d      = LS_MC_wr;
                    dout_d    = LS_MC_wr ? LS_MC_data[7:0] : dout_q;
                end else if (!clr_in && grant_if) begin
                    state_d   = IF_READ;
                    base_d    = IF_MC_Addr;
                    addr_d    = IF_MC_Addr;
                    len_d     = 3'd4;
                    cnt_d     = 3'd0;
                    rbuf_d    = 32'd0;
                    if_ok_d   = 1'b1;
                    last_ls_d = 1'b0;
                end
            end
            IF_READ, LS_READ: begin
                // Synchronous RAM: byte k lands two edges after its address
                if (clr_in) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc < len_q)
                        addr_d = base_q + ADDR_W'(cnt_inc);
                    if (cnt_q != 3'd0)
                        rbuf_d[{rd_idx, 3'b000} +: 8] = mem_din;
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                        if (state_q == IF_READ) begin
                            if_arr_d = 1'b1;
                            inst_d   = rbuf_d;
                        end else begin
                            ls_arr_d  = 1'b1;
                            ls_data_d = rbuf_d;
                        end
                    end
                end
            end
            LS_WRITE: begin
                if (cnt_inc < len_q) begin
                    cnt_d  = cnt_inc;
                    addr_d = base_q + ADDR_W'(cnt_inc);
                    dout_d = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
                    wr_d   = 1'b1;
                end else begin
                    state_d  = IDLE;
                    ls_arr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            base_q    <= '0;
            cnt_q     <= 3'd0;
            len_q     <= 3'd0;
            wdata_q   <= 32'd0;
            rbuf_q    <= 32'd0;
            last_ls_q <= 1'b0;
            dout_q    <= 8'd0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            if_ok_q   <= 1'b0;
            if_arr_q  <= 1'b0;
            ls_ok_q   <= 1'b0;
            ls_arr_q  <= 1'b0;
            inst_q    <= 32'd0;
            ls_data_q <= 32'd0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            wdata_q   <= wdata_d;
            rbuf_q    <= rbuf_d;
            last_ls_q <= last_ls_d;
            dout_q    <= dout_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            if_ok_q   <= if_ok_d;
            if_arr_q  <= if_arr_d;
            ls_ok_q   <= ls_ok_d;
            ls_arr_q  <= ls_arr_d;
            inst_q    <= inst_d;
            ls_data_q <= ls_data_d;
        end
    end

    assign mem_dout     = dout_q;
    assign mem_a        = addr_q;
    assign mem_wr       = wr_q & rdy_in;
    assign MC_IF_ok     = if_ok_q;
    assign MC_IF_arrive = if_arr_q;
    assign MC_IF_Inst   = inst_q;
    assign MC_LS_ok     = ls_ok_q;
    assign MC_LS_arrive = ls_arr_q;
    assign MC_LS_data   = ls_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Self-checking bench for mem_ctrl with synchronous RAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk_in, rst_in, rdy_in, clr_in, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        IF_MC_ask, MC_IF_ok, MC_IF_arrive;
    logic [31:0] IF_MC_Addr, MC_IF_Inst;
    logic        LS_MC_ask, LS_MC_wr, MC_LS_ok, MC_LS_arrive;
    logic [31:0] LS_MC_Addr, LS_MC_data, MC_LS_data;
    logic [1:0]  LS_MC_len;

    mem_ctrl #(.ADDR_W(32), .IO_BASE(32'h30000)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .IF_MC_ask(IF_MC_ask), .IF_MC_Addr(IF_MC_Addr), .MC_IF_ok(MC_IF_ok),
        .MC_IF_arrive(MC_IF_arrive), .MC_IF_Inst(MC_IF_Inst),
        .LS_MC_ask(LS_MC_ask), .LS_MC_wr(LS_MC_wr), .LS_MC_Addr(LS_MC_Addr),
        .LS_MC_len(LS_MC_len), .LS_MC_data(LS_MC_data), .MC_LS_ok(MC_LS_ok),
        .MC_LS_arrive(MC_LS_arrive), .MC_LS_data(MC_LS_data)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Synchronous byte RAM; it freezes together with the rest of the system
    logic [7:0] ram [logic [31:0]];
    always @(posedge clk_in) begin
        if (rdy_in) begin
            mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
            if (mem_wr) ram[mem_a] = mem_dout;
        end
    end

    typedef struct packed {
        logic        is_load;
        logic [31:0] d;
    } exp_t;

    typedef struct {
        bit          is_if;
        bit          wr;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    logic [31:0] if_q[$];
    exp_t        ls_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    always @(negedge clk_in) begin
        if (rst_in) begin
            if (MC_IF_arrive) begin
                if (if_q.size() == 0) fail_evt("if_unexpected_arrive");
                else chk("if_inst", MC_IF_Inst, if_q.pop_front());
            end
            if (MC_LS_arrive) begin
                if (ls_q.size() == 0) fail_evt("ls_unexpected_arrive");
                else begin
                    exp_t e;
                    e = ls_q.pop_front();
                    if (e.is_load) chk("ls_data", MC_LS_data, e.d);
                end
            end
            if (MC_IF_ok || MC_IF_arrive || MC_LS_ok || MC_LS_arrive) begin
                chk("pulse_overlap", 32'((MC_IF_ok | MC_IF_arrive) & (MC_LS_ok | MC_LS_arrive)), 0);
                chk("ok_arrive_same", 32'((MC_IF_ok & MC_IF_arrive) | (MC_LS_ok & MC_LS_arrive)), 0);
            end
        end
    end

    task automatic issue(input vec_t v);
        int n;
        exp_t e;
        if (v.is_if) begin
            IF_MC_ask = 1'b1; IF_MC_Addr = v.addr; if_q.push_back(v.exp);
        end else begin
            LS_MC_ask = 1'b1; LS_MC_wr = v.wr; LS_MC_Addr = v.addr;
            LS_MC_len = v.len; LS_MC_data = v.data;
            e.is_load = !v.wr; e.d = v.exp; ls_q.push_back(e);
        end
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!(v.is_if ? MC_IF_ok : MC_LS_ok) && n < 100);
        if (!(v.is_if ? MC_IF_ok : MC_LS_ok)) fail_evt("issue_timeout");
        IF_MC_ask = 1'b0;
        LS_MC_ask = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((if_q.size() != 0 || ls_q.size() != 0) && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        if (if_q.size() != 0 || ls_q.size() != 0) fail_evt("drain_timeout");
        if_q.delete();
        ls_q.delete();
        @(negedge clk_in);
    endtask

    vec_t vecs[11];
    exp_t ex;
    int   g[4];
    int   ng, cnt, wcnt;

    initial begin
        vecs[0]  = '{0, 1, 32'h40,       2'd0, 32'h000000A5, 32'h0};
        vecs[1]  = '{0, 1, 32'h100,      2'd3, 32'h11223344, 32'h0};
        vecs[2]  = '{0, 0, 32'h100,      2'd3, 32'h0,        32'h11223344};
        vecs[3]  = '{0, 0, 32'h100,      2'd2, 32'h0,        32'h11223344};
        vecs[4]  = '{0, 0, 32'h40,       2'd0, 32'h0,        32'h000000A5};
        vecs[5]  = '{0, 0, 32'h21,       2'd0, 32'h0,        32'h000000BE};
        vecs[6]  = '{1, 0, 32'h100,      2'd0, 32'h0,        32'h11223344};
        vecs[7]  = '{0, 1, 32'hFFFFFFFE, 2'd3, 32'hCAFEF00D, 32'h0};
        vecs[8]  = '{0, 0, 32'hFFFFFFFE, 2'd3, 32'h0,        32'hCAFEF00D};
        vecs[9]  = '{0, 0, 32'h102,      2'd1, 32'h0,        32'h00001122};
        vecs[10] = '{0, 0, 32'h1,        2'd0, 32'h0,        32'h000000CA};

        ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h00;
        ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
        rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; io_buffer_full = 1'b0;
        IF_MC_ask = 1'b0; IF_MC_Addr = 32'h0;
        LS_MC_ask = 1'b0; LS_MC_wr = 1'b0; LS_MC_Addr = 32'h0;
        LS_MC_len = 2'd0; LS_MC_data = 32'h0;
        #2 rst_in = 1'b0;
        #1;
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_oks", 32'({MC_IF_ok, MC_LS_ok, MC_IF_arrive, MC_LS_arrive}), 0);
        chk("rst_inst", MC_IF_Inst, 0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);

        // Fetch timing: address per byte, arrive one cycle after E5
        IF_MC_ask = 1'b1; IF_MC_Addr = 32'h1000; if_q.push_back(32'h13);
        @(negedge clk_in);
        chk("A_ok", 32'(MC_IF_ok), 1);
        chk("A_addr0", mem_a, 32'h1000);
        chk("A_rd", 32'(mem_wr), 0);
        IF_MC_ask = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk_in);
            chk("A_addr", mem_a, 32'h1000 + 32'(k));
        end
        @(negedge clk_in);
        chk("A_early_arrive", 32'(MC_IF_arrive), 0);
        @(negedge clk_in);
        chk("A_arrive", 32'(MC_IF_arrive), 1);
        @(negedge clk_in);
        chk("A_arrive_pulse", 32'(MC_IF_arrive), 0);
        wait_drain();

        // Arbitration alternation from a fresh reset (last grant = IF)
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        IF_MC_ask = 1'b1; IF_MC_Addr = 32'h1000;
        LS_MC_ask = 1'b1; LS_MC_wr = 1'b0; LS_MC_Addr = 32'h1000; LS_MC_len = 2'd0;
        ng = 0;
        for (int i = 0; i < 100 && ng < 4; i++) begin
            @(negedge clk_in);
            if (MC_LS_ok) begin g[ng] = 0; ng++; ex = '{1'b1, 32'h13}; ls_q.push_back(ex); end
            if (MC_IF_ok) begin g[ng] = 1; ng++; if_q.push_back(32'h13); end
        end
        IF_MC_ask = 1'b0; LS_MC_ask = 1'b0;
        chk("B_grants", 32'(ng), 4);
        for (int i = 0; i < ng; i++) chk("B_order", 32'(g[i]), 32'(i % 2));
        wait_drain();

        // Two-byte store, byte by byte
        LS_MC_ask = 1'b1; LS_MC_wr = 1'b1; LS_MC_Addr = 32'h20;
        LS_MC_len = 2'd1; LS_MC_data = 32'h0000BEEF;
        ex = '{1'b0, 32'h0}; ls_q.push_back(ex);
        @(negedge clk_in);
        chk("C_ok", 32'(MC_LS_ok), 1);
        chk("C_b0", {mem_a[23:0], mem_dout}, {24'h20, 8'hEF});
        chk("C_wr0", 32'(mem_wr), 1);
        LS_MC_ask = 1'b0;
        @(negedge clk_in);
        chk("C_b1", {mem_a[23:0], mem_dout}, {24'h21, 8'hBE});
        chk("C_wr1", 32'(mem_wr), 1);
        @(negedge clk_in);
        chk("C_wr_end", 32'(mem_wr), 0);
        chk("C_arrive", 32'(MC_LS_arrive), 1);
        wait_drain();
        issue('{0, 0, 32'h20, 2'd1, 32'h0, 32'h0000BEEF});
        wait_drain();

        // IO store blocked while the UART buffer is full
        io_buffer_full = 1'b1;
        LS_MC_ask = 1'b1; LS_MC_wr = 1'b1; LS_MC_Addr = 32'h30000;
        LS_MC_len = 2'd0; LS_MC_data = 32'h41;
        IF_MC_ask = 1'b1; IF_MC_Addr = 32'h1000; if_q.push_back(32'h13);
        @(negedge clk_in);
        chk("D_if_ok", 32'(MC_IF_ok), 1);
        chk("D_ls_not_ok", 32'(MC_LS_ok), 0);
        IF_MC_ask = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            if (MC_LS_ok || mem_wr) cnt++;
        end
        chk("D_ls_blocked", 32'(cnt), 0);
        io_buffer_full = 1'b0;
        ex = '{1'b0, 32'h0}; ls_q.push_back(ex);
        cnt = 0; wcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (MC_LS_ok) begin cnt++; LS_MC_ask = 1'b0; end
            if (mem_wr && mem_a == 32'h30000 && mem_dout == 8'h41) wcnt++;
        end
        chk("D_ls_granted", 32'(cnt), 1);
        chk("D_io_writes", 32'(wcnt), 1);
        wait_drain();

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i]);
            wait_drain();
        end

        // Flush during a fetch: aborted, controller idle right after
        IF_MC_ask = 1'b1; IF_MC_Addr = 32'h1000;
        @(negedge clk_in);
        chk("E_if_ok", 32'(MC_IF_ok), 1);
        IF_MC_ask = 1'b0;
        @(negedge clk_in);
        clr_in = 1'b1;
        @(negedge clk_in);
        clr_in = 1'b0;
        LS_MC_ask = 1'b1; LS_MC_wr = 1'b0; LS_MC_Addr = 32'h1000; LS_MC_len = 2'd0;
        ex = '{1'b1, 32'h13}; ls_q.push_back(ex);
        @(negedge clk_in);
        chk("E_regrant", 32'(MC_LS_ok), 1);
        LS_MC_ask = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            if (MC_IF_arrive) cnt++;
        end
        chk("E_no_if_arrive", 32'(cnt), 0);
        wait_drain();

        // Flush during a store is ignored
        LS_MC_ask = 1'b1; LS_MC_wr = 1'b1; LS_MC_Addr = 32'h200;
        LS_MC_len = 2'd3; LS_MC_data = 32'hDEADBEEF;
        ex = '{1'b0, 32'h0}; ls_q.push_back(ex);
        wcnt = 0; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            if (MC_LS_ok) LS_MC_ask = 1'b0;
            if (mem_wr) wcnt++;
            if (MC_LS_arrive) cnt++;
            clr_in = (i == 1);
        end
        clr_in = 1'b0;
        chk("E_st_bytes", 32'(wcnt), 4);
        chk("E_st_arrive", 32'(cnt), 1);
        wait_drain();
        issue('{0, 0, 32'h200, 2'd3, 32'h0, 32'hDEADBEEF});
        wait_drain();

        // Freeze for three cycles in the middle of a fetch
        IF_MC_ask = 1'b1; IF_MC_Addr = 32'h100; if_q.push_back(32'h11223344);
        @(negedge clk_in);
        IF_MC_ask = 1'b0;
        @(negedge clk_in);
        chk("F_addr1", mem_a, 32'h101);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("F_frz_addr", mem_a, 32'h101);
            chk("F_frz_wr", 32'(mem_wr), 0);
        end
        rdy_in = 1'b1;
        wait_drain();

        // Freeze mid-store gates mem_wr; async reset then clears everything
        LS_MC_ask = 1'b1; LS_MC_wr = 1'b1; LS_MC_Addr = 32'h300;
        LS_MC_len = 2'd3; LS_MC_data = 32'h55667788;
        @(negedge clk_in);
        chk("G_wr", 32'(mem_wr), 1);
        LS_MC_ask = 1'b0;
        @(negedge clk_in);
        chk("G_b1", {mem_a[23:0], mem_dout}, {24'h301, 8'h77});
        rdy_in = 1'b0;
        @(negedge clk_in);
        chk("G_wr_gated", 32'(mem_wr), 0);
        chk("G_frz_addr", mem_a, 32'h301);
        #2 rst_in = 1'b0;
        #1;
        chk("G_rst_addr", mem_a, 0);
        chk("G_rst_dout", 32'(mem_dout), 0);
        chk("G_rst_inst", MC_IF_Inst, 0);
        chk("G_rst_lsdata", MC_LS_data, 0);
        if_q.delete();
        ls_q.delete();
        rdy_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("G_post_wr", 32'(mem_wr), 0);
        issue('{1, 0, 32'h1000, 2'd0, 32'h0, 32'h13});
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sole owner of the byte-wide RAM/IO port.
- Arbitrates between the instruction fetcher (4-byte instruction reads) and the load/store buffer (1/2/4-byte loads and stores).
- Serialises each access into byte transfers, assembles read data little-endian, and returns it with an arrive pulse.
- Sits between the fetch/LSB units and the top-level RAM interface.

Parameters:
- ADDR_W, 32, address width
- IO_BASE, 32'h30000, base of the IO window (IO_BASE..IO_BASE+7)

Ports:
- clk_in  in  1  clock; all state updates on posedge
- rst_in  in  1  asynchronous, active-low reset; asserting low immediately forces reset state
- rdy_in  in  1  high = run; low = freeze all state
- clr_in  in  1  pipeline flush (mispredict)
- io_buffer_full  in  1  UART buffer full
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_W  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- IF_MC_ask  in  1  fetch request
- IF_MC_Addr  in  ADDR_W  fetch address
- MC_IF_ok  out  1  fetch request accepted (1-cycle pulse)
- MC_IF_arrive  out  1  instruction valid (1-cycle pulse)
- MC_IF_Inst  out  32  instruction
- LS_MC_ask  in  1  load/store request
- LS_MC_wr  in  1  1 = store
- LS_MC_Addr  in  ADDR_W  byte address
- LS_MC_len  in  2  0 = 1B, 1 = 2B, 3 = 4B (2 illegal, treated as 4B)
- LS_MC_data  in  32  store data; low bytes used
- MC_LS_ok  out  1  accepted (1-cycle pulse)
- MC_LS_arrive  out  1  load data valid / store done (1-cycle pulse)
- MC_LS_data  out  32  load data, zero-extended

Behaviour:
- Reset (rst_in low, async): state IDLE; all outputs 0; mem_a = 0; byte counter 0; last_grant = IF.
- rdy_in low: state, counters and outputs hold. mem_wr is gated to 0 combinationally while rdy_in is low. Operation resumes exactly where it stopped.
- States: IDLE, IF_READ, LS_READ, LS_WRITE.
- IDLE arbitration on edge E0. Requests are sampled only in IDLE.
  - Both ask: grant LS, unless last_grant = LS, in which case grant IF (alternation, no starvation).
  - A store to the IO window while io_buffer_full = 1 is not granted; the IF request may be granted instead. The store is re-evaluated every IDLE cycle.
  - The granted side sees ok = 1 for the one cycle after E0. last_grant is updated.
- Reads (n = 4 for IF, 1/2/4 for LS):
  - Address for byte k is driven after edge Ek (k = 0..n-1), mem_wr = 0.
  - RAM is synchronous: byte k is captured from mem_din at edge E(k+2).
  - Last byte is captured at E(n+1). The arrive pulse and assembled data are valid in the cycle after E(n+1), and state returns to IDLE there.
  - Byte k goes to data[8k+7:8k]. Unused bytes are 0.
  - MC_IF_Inst / MC_LS_data hold their value until the next arrive.
- Writes:
  - Byte k is driven after Ek with mem_a = addr+k, mem_dout = data[8k+7:8k], mem_wr = 1 (k = 0..n-1).
  - After En: mem_wr = 0, MC_LS_arrive = 1 for one cycle, state IDLE.
- Address arithmetic is modulo 2^ADDR_W; addr+k wraps.
- Requesters drop ask on seeing ok. An ask still high when the controller returns to IDLE is treated as a new request.
- ok and arrive never assert in the same cycle for the same side. IF and LS pulses never overlap.
- clr_in = 1 at an edge:
  - IF_READ or LS_READ: abort to IDLE, no arrive, mem_wr = 0.
  - LS_WRITE: ignored; the write completes.
  - IDLE: no grant at that edge.
- Earliest re-grant is edge E(n+2) for reads and E(n+1) for writes.

Test Plan:
- IF reads 0x1000 (RAM bytes 13,00,00,00 at 0x1000..0x1003): ok after E0; mem_a = 0x1000..0x1003 after E0..E3; arrive one cycle after E5 with Inst = 0x00000013.
- Both ask at the same edge after reset (last_grant = IF): LS granted first, IF granted next. With both held asking, grants alternate LS, IF, LS, IF.
- LS 2-byte store of 0xBEEF to 0x20: mem_wr = 1 with (0x20, EF) then (0x21, BE); arrive after E2. A following 2-byte load of 0x20 returns MC_LS_data = 0x0000BEEF.
- 1-byte store to 0x30000 with io_buffer_full = 1 and IF asking: IF is granted, the store waits. Drop full: store granted, mem_wr = 1 at 0x30000 for one cycle.
- clr_in asserted at E2 of an IF_READ: no MC_IF_arrive, IDLE next cycle. clr_in mid-LS_WRITE: all 4 bytes still written and arrive pulses.
- rdy_in low for 3 cycles mid-read, then rst_in pulsed low mid-write: freeze holds state with mem_wr = 0 throughout. Reset clears all outputs immediately, without waiting for a clock edge.
